data_pack: RTL and testbench
============================

# data_pack

Packs a stream of 7-bit packets into 32-bit words, LSB-first, with no gaps between packets; a packet that straddles a word boundary is split across consecutive words. It is the transmit-side counterpart of the word-to-packet unpacker: its output word stream, fed to the unpacker, reproduces the original packet sequence. It sits between a packet source (valid/ready) and a 32-bit word sink (valid/ready). A flush request emits any partial word zero-padded.

## Interface
- PKT_W, 7, packet width; only the default is verified.
- WORD_W, 32, output word width; only the default is verified.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- pkt_in  input  7  packet data
- pkt_valid  input  1  pkt_in is valid
- pkt_ready  output  1  block accepts pkt_in this cycle; a transfer occurs when pkt_valid and pkt_ready are both high
- flush  input  1  single-cycle request to emit the current partial word
- word_out  output  32  packed word, registered
- word_valid  output  1  word_out holds an unconsumed word
- word_ready  input  1  sink consumes word_out; a transfer occurs when word_valid and word_ready are both high
- flush_done  output  1  one-cycle pulse when a flush has completed
- fill  output  5  bits currently held in the accumulator, range 0..31

## Operation
- **Accumulator.** acc is 38 bits; fill is kept internally as 6 bits. An accepted packet is ORed in at bit position fill: acc |= pkt_in << fill, and fill += 7.
- **Word completion.** If fill+7 >= 32, a word completes:
  - word_out <= low 32 bits of the merged acc;
  - word_valid <= 1;
  - acc <= merged acc >> 32;
  - fill <= fill+7-32.
- **Bit ordering.** The first packet of a word occupies bits [6:0], the next [13:7], and so on. The 5th packet of a cycle splits 4 bits / 3 bits. After 32 packets the pattern re-aligns (fill = 0).
- **Output slot.** The output is a single slot. word_valid clears on word_ready unless a new word completes in the same cycle, in which case the new word is loaded and word_valid stays 1.
- **pkt_ready** = (state == ACCUM) && ((fill+7 < 32) || !word_valid || word_ready). A completing packet is never accepted while the slot is full and not draining.
- **States:**
  - ACCUM: normal packing. flush high → FLUSH. A packet accepted in the same cycle as flush is included in the flush.
  - FLUSH: pkt_ready = 0.
    - If fill == 0 → DONE with no word emitted.
    - If fill > 0 and the slot is free or draining (!word_valid || word_ready): word_out <= acc[31:0] with the upper bits zero, word_valid <= 1, acc <= 0, fill <= 0 → DONE.
    - Otherwise stay in FLUSH.
  - DONE: flush_done = 1 for this cycle only → ACCUM.
- **flush outside ACCUM.** A flush asserted in FLUSH or DONE is ignored.
- **Unused bits.** Bits of acc above fill are always 0.

## Timing
- **Reset values.** All outputs and internal state go to zero asynchronously on rst:
  - word_out = 0, word_valid = 0, flush_done = 0, fill = 0;
  - acc = 0, state = ACCUM.
- **Reset while a word is pending.** The pending word is discarded.
- **Latency.** A packet accepted at edge N that completes a word gives word_valid = 1 and word_out updated after edge N (visible in cycle N+1).
- **Throughput.** One packet per cycle with no bubbles while word_ready is held high.
- **Flush timing.** With fill > 0 and a free slot, flush sampled at edge N gives:
  - the padded word visible after edge N+1;
  - flush_done high in the cycle after edge N+2;
  - pkt_ready back to 1 in the cycle after edge N+3.
- **Flush with fill == 0.** flush_done high in the cycle after edge N+2, with no word emitted.
- **Backpressure during flush.** While word_valid is high and word_ready is low, FLUSH waits indefinitely. word_out remains stable while word_valid && !word_ready.
- **fill output.** Registered; it reflects the state after the last edge.

## Test plan
- **Basic packing.** Packets 0x01, 0x02, 0x03, 0x04, 0x05 with word_ready = 1 → one word 0x5080C101 after the 5th packet; fill = 3; acc holds 0.
- **Full alignment.** 5 packets of 0x7F → word 0xFFFFFFFF, fill = 3, acc[2:0] = 3'b111. Continuing to 32 packets of 0x7F → exactly 7 words of 0xFFFFFFFF, then fill = 0.
- **Flush with partial word.** 3 packets of 0x7F, then flush → word 0x001FFFFF, flush_done pulses once, fill = 0. A second flush with fill = 0 → flush_done pulse and no word.
- **Backpressure.** Hold word_ready = 0 after the first word completes:
  - word_out stays stable and word_valid stays 1;
  - pkt_ready drops exactly when fill+7 >= 32 (fill = 31 after packets 5..9);
  - release word_ready → the next word is loaded in the same cycle the old one drains.
- **Simultaneous packet and flush.** Flush coincides with an accepted 0x55 packet at fill = 0 → emitted word 0x00000055 and flush_done.
- **Reset mid-operation.** Assert rst with word_valid = 1 and fill = 10 → all outputs 0 immediately (asynchronously). After release, packing restarts at bit 0.

Source files
------------

// File: rtl/data_pack.sv
// Packs a stream of PKT_W-bit packets LSB-first into WORD_W-bit words with a single output slot.
// A flush emits any partial word zero-padded, followed by a one-cycle flush_done pulse.
module data_pack #(
  parameter int unsigned PKT_W  = 7,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              flush_done,
  output logic [$clog2(WORD_W)-1:0] fill
);

  localparam int unsigned AccW  = WORD_W + PKT_W - 1;
  localparam int unsigned FillW = $clog2(WORD_W + PKT_W);

  typedef enum logic [1:0] {StAccum, StFlush, StDone} state_e;

  state_e           state_q;
  logic [AccW-1:0]  acc_q;
  logic [FillW-1:0] fill_q;

  logic [AccW-1:0]  merged;
  logic [FillW-1:0] fill_sum;
  logic             completes;
  logic             slot_free;
  logic             accept;

  always_comb begin
    merged    = acc_q | (AccW'(pkt_in) << fill_q);
    fill_sum  = fill_q + FillW'(PKT_W);
    completes = fill_sum >= FillW'(WORD_W);
    slot_free = !word_valid || word_ready;
    pkt_ready = (state_q == StAccum) && (!completes || slot_free);
    accept    = pkt_valid && pkt_ready;
  end

  assign fill = fill_q[$clog2(WORD_W)-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      fill_q     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      // A load below overrides this drain, keeping word_valid high.
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      unique case (state_q)
        StAccum: begin
          flush_done <= 1'b0;
          if (accept) begin
            if (completes) begin
              word_out   <= merged[WORD_W-1:0];
              word_valid <= 1'b1;
              acc_q      <= merged >> WORD_W;
              fill_q     <= fill_sum - FillW'(WORD_W);
            end else begin
              acc_q  <= merged;
              fill_q <= fill_sum;
            end
          end
          if (flush) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          flush_done <= 1'b0;
          if (fill_q == '0) begin
            state_q <= StDone;
          end else if (slot_free) begin
            // Bits above fill are always zero, so the low word is already padded.
            word_out   <= acc_q[WORD_W-1:0];
            word_valid <= 1'b1;
            acc_q      <= '0;
            fill_q     <= '0;
            state_q    <= StDone;
          end
        end
        StDone: begin
          // Raise the pulse for one cycle, then return to packing.
          flush_done <= !flush_done;
          if (flush_done) begin
            state_q <= StAccum;
          end
        end
        default: begin
          state_q    <= StAccum;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_pack.sv
// Bench for data_pack: a bit-queue model checked every cycle plus directed literal expectations.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  pkt_in = '0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic        flush = 1'b0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        flush_done;
  logic [4:0]  fill;

  int total = 0;
  int bad   = 0;

  data_pack dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_in     (pkt_in),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .flush      (flush),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .flush_done (flush_done),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bits as a queue (index 0 = next bit to go out), one output slot,
  // and a flush phase: 0 packing, 1 flushing, 2 done (pulse low), 3 done (pulse high).
  bit          mq[$];
  logic        m_v = 1'b0;
  logic [31:0] m_d = '0;
  int          ph  = 0;

  function automatic logic m_ready();
    return (ph == 0) && ((mq.size() + 7 < 32) || !m_v || word_ready);
  endfunction

  always @(negedge clk) begin
    logic acc;
    logic [31:0] w;
    if (rst) begin
      mq.delete();
      m_v = 1'b0;
      m_d = '0;
      ph  = 0;
    end
    chk("word_valid", {31'd0, word_valid}, {31'd0, m_v});
    chk("fill", {27'd0, fill}, 32'(mq.size()));
    chk("flush_done", {31'd0, flush_done}, {31'd0, ph == 3});
    chk("pkt_ready", {31'd0, pkt_ready}, {31'd0, m_ready()});
    if (m_v) chk("word_out", word_out, m_d);
    if (!rst) begin
      acc = pkt_valid && m_ready();
      if (m_v && word_ready) m_v = 1'b0;
      case (ph)
        0: begin
          if (acc) begin
            for (int i = 0; i < 7; i++) mq.push_back(pkt_in[i]);
            if (mq.size() >= 32) begin
              for (int i = 0; i < 32; i++) w[i] = mq.pop_front();
              m_v = 1'b1;
              m_d = w;
            end
          end
          if (flush) ph = 1;
        end
        1: begin
          if (mq.size() == 0) begin
            ph = 2;
          end else if (!m_v) begin
            w = '0;
            for (int i = 0; i < mq.size(); i++) w[i] = mq[i];
            mq.delete();
            m_v = 1'b1;
            m_d = w;
            ph  = 2;
          end
        end
        2: ph = 3;
        default: ph = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] p);
    int n = 0;
    pkt_in    = p;
    pkt_valid = 1'b1;
    while (!pkt_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    step();
    pkt_valid = 1'b0;
  endtask

  task automatic do_flush();
    int n = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    while (!flush_done && n < 50) begin
      step();
      n++;
    end
    chk("flush_wait", {31'd0, flush_done}, 32'd1);
    step();
  endtask

  initial begin
    int nw;
    step();
    step();
    chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_word_out", word_out, 32'd0);
    chk("rst_fill", {27'd0, fill}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    rst = 1'b0;
    word_ready = 1'b1;

    // Basic packing.
    for (int i = 1; i <= 5; i++) send(7'(i));
    chk("basic_valid", {31'd0, word_valid}, 32'd1);
    chk("basic_word", word_out, 32'h5080C101);
    chk("basic_fill", {27'd0, fill}, 32'd3);
    do_flush();

    // Full alignment over 32 packets.
    nw = 0;
    for (int i = 0; i < 32; i++) begin
      send(7'h7F);
      if (word_valid) nw++;
      if (i == 4) begin
        chk("align_word", word_out, 32'hFFFFFFFF);
        chk("align_fill", {27'd0, fill}, 32'd3);
      end
    end
    chk("align_words", 32'(nw), 32'd7);
    chk("align_fill_end", {27'd0, fill}, 32'd0);
    step();

    // Flush with a partial word, then a flush with nothing held.
    for (int i = 0; i < 3; i++) send(7'h7F);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'd0, pkt_ready}, 32'd0);
    step();
    chk("flush_valid", {31'd0, word_valid}, 32'd1);
    chk("flush_word", word_out, 32'h001FFFFF);
    chk("flush_fill", {27'd0, fill}, 32'd0);
    chk("flush_done_early", {31'd0, flush_done}, 32'd0);
    step();
    chk("flush_done_pulse", {31'd0, flush_done}, 32'd1);
    step();
    chk("flush_done_clear", {31'd0, flush_done}, 32'd0);
    chk("flush_ready_back", {31'd0, pkt_ready}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("flush0_novalid", {31'd0, word_valid}, 32'd0);
    step();
    chk("flush0_done", {31'd0, flush_done}, 32'd1);
    chk("flush0_novalid2", {31'd0, word_valid}, 32'd0);
    step();

    // Backpressure.
    word_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(7'(i));
    chk("bp_fill", {27'd0, fill}, 32'd31);
    chk("bp_valid", {31'd0, word_valid}, 32'd1);
    chk("bp_word", word_out, 32'h5080C101);
    pkt_in    = 7'h0A;
    pkt_valid = 1'b1;
    #1;
    chk("bp_stall", {31'd0, pkt_ready}, 32'd0);
    step();
    step();
    chk("bp_stable", word_out, 32'h5080C101);
    word_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, pkt_ready}, 32'd1);
    step();
    pkt_valid = 1'b0;
    chk("bp_next_valid", {31'd0, word_valid}, 32'd1);
    chk("bp_next_word", word_out, 32'h09101C30);
    chk("bp_next_fill", {27'd0, fill}, 32'd6);
    do_flush();

    // Packet and flush in the same cycle.
    pkt_in    = 7'h55;
    pkt_valid = 1'b1;
    flush     = 1'b1;
    #1;
    chk("sim_ready", {31'd0, pkt_ready}, 32'd1);
    step();
    pkt_valid = 1'b0;
    flush     = 1'b0;
    step();
    chk("sim_valid", {31'd0, word_valid}, 32'd1);
    chk("sim_word", word_out, 32'h00000055);
    step();
    chk("sim_done", {31'd0, flush_done}, 32'd1);
    step();

    // Reset while a word is pending.
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(7'h7F);
    chk("mid_fill", {27'd0, fill}, 32'd10);
    chk("mid_valid", {31'd0, word_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, word_valid}, 32'd0);
    chk("arst_word", word_out, 32'd0);
    chk("arst_fill", {27'd0, fill}, 32'd0);
    chk("arst_done", {31'd0, flush_done}, 32'd0);
    step();
    rst = 1'b0;
    word_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(7'(i));
    chk("restart_word", word_out, 32'h5080C101);
    chk("restart_fill", {27'd0, fill}, 32'd3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
